// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline stall/flush controller.
package pipeline_ctrl_pkg;

    // Default pipeline widths shared by the hazard controller and forwarding logic
    localparam int REG_ADDR_W      = 5;
    localparam int CNT_W           = 16;
    localparam int MEM_TIMEOUT_DEF = 255;

    // Hard-wired zero register; a load targeting it never creates a hazard
    localparam int unsigned REG_X0 = 0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_t;

    // Which priority branch of the output mux is active this cycle
    typedef enum logic [1:0] {
        SEL_NORMAL   = 2'd0,
        SEL_FREEZE   = 2'd1,
        SEL_BRANCH   = 2'd2,
        SEL_LOAD_USE = 2'd3
    } ctrl_sel_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID. Purely combinational so the forwarding unit can reuse it.
module load_use_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_W
) (
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_mem_read,
    output logic                      load_use
);

    logic rd_live;
    logic rs1_hit;
    logic rs2_hit;

    // Compare both ID operands against the pending load destination, ignoring x0
    always_comb begin
        rd_live  = ex_mem_read && (ex_rd != REG_ADDR_WIDTH'(REG_X0));
        rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
        load_use = rd_live && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: priority mux over
// memory wait, taken branch and load-use, plus memory-timeout FSM and
// saturating performance counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_W,
    parameter int MEM_TIMEOUT    = MEM_TIMEOUT_DEF,
    parameter int CNT_WIDTH      = CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_mem_read,
    input  logic                      ex_branch_taken,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      pc_write_en,
    output logic                      ifid_write_en,
    output logic                      idex_write_en,
    output logic                      exmem_write_en,
    output logic                      ifid_flush,
    output logic                      idex_flush,
    output logic                      memwb_flush,
    output logic                      halted,
    output logic [CNT_WIDTH-1:0]      stall_cycles,
    output logic [CNT_WIDTH-1:0]      flush_events
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    ctrl_state_t       state, state_nxt;
    ctrl_sel_t         sel;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              load_use;
    logic              mem_stall;
    logic              stall_inc;
    logic              flush_inc;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    load_use_detect #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_load_use (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    assign mem_stall = mem_req && !mem_ready;

    // FSM state, wait counter and performance counters; all cleared on reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (stall_inc) stall_cycles <= sat_inc(stall_cycles);
            if (flush_inc) flush_events <= sat_inc(flush_events);
        end
    end

    // Next state plus Mealy priority mux; a branch held during MEM_WAIT is
    // kept alive by the ID/EX and EX/MEM freeze and wins on the release cycle
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        sel            = SEL_NORMAL;
        pc_write_en    = 1'b0;
        ifid_write_en  = 1'b0;
        idex_write_en  = 1'b0;
        exmem_write_en = 1'b0;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        memwb_flush    = 1'b0;
        halted         = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        if (!reset) begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
        end else if (state == HALT) begin
            memwb_flush = 1'b1;
            halted      = 1'b1;
        end else begin
            if (mem_stall)            sel = SEL_FREEZE;
            else if (ex_branch_taken) sel = SEL_BRANCH;
            else if (load_use)        sel = SEL_LOAD_USE;
            else                      sel = SEL_NORMAL;

            case (sel)
                SEL_FREEZE: begin
                    memwb_flush = 1'b1;
                end
                SEL_BRANCH: begin
                    pc_write_en    = 1'b1;
                    ifid_write_en  = 1'b1;
                    idex_write_en  = 1'b1;
                    exmem_write_en = 1'b1;
                    ifid_flush     = 1'b1;
                    idex_flush     = 1'b1;
                end
                SEL_LOAD_USE: begin
                    idex_write_en  = 1'b1;
                    idex_flush     = 1'b1;
                    exmem_write_en = 1'b1;
                end
                default: begin
                    pc_write_en    = 1'b1;
                    ifid_write_en  = 1'b1;
                    idex_write_en  = 1'b1;
                    exmem_write_en = 1'b1;
                end
            endcase

            stall_inc = !pc_write_en;
            flush_inc = (sel == SEL_BRANCH);

            if (state == RUN) begin
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end else begin
                if (!mem_stall) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == TIMEOUT_V) begin
                    state_nxt = HALT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a driver applies directed vectors
// and queues hand-computed responses; a monitor checks them each cycle.
module tb_pipeline_hazard_ctrl;

    // ctl bit order: {pc, ifid, idex, exmem write_en, ifid, idex, memwb flush, halted}
    localparam logic [7:0] C_NORM   = 8'hF0;
    localparam logic [7:0] C_FREEZE = 8'h02;
    localparam logic [7:0] C_BRANCH = 8'hFC;
    localparam logic [7:0] C_LU     = 8'h34;
    localparam logic [7:0] C_HALT   = 8'h03;
    localparam logic [7:0] C_RST    = 8'h00;

    typedef struct {
        string      nm;
        logic [7:0] ctl;
        logic [3:0] st;
        logic [3:0] fl;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic       mem_req, mem_ready;
    logic       pc_write_en, ifid_write_en, idex_write_en, exmem_write_en;
    logic       ifid_flush, idex_flush, memwb_flush, halted;
    logic [3:0] stall_cycles, flush_events;
    logic [7:0] dut_ctl;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_WIDTH(5),
        .MEM_TIMEOUT   (4),
        .CNT_WIDTH     (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_write_en    (pc_write_en),
        .ifid_write_en  (ifid_write_en),
        .idex_write_en  (idex_write_en),
        .exmem_write_en (exmem_write_en),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .memwb_flush    (memwb_flush),
        .halted         (halted),
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
    );

    assign dut_ctl = {pc_write_en, ifid_write_en, idex_write_en, exmem_write_en,
                      ifid_flush, idex_flush, memwb_flush, halted};

    // Drive one cycle of inputs just after the edge and queue the expected response
    task automatic apply(input string nm, input logic rst_n,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic mr, input logic bt,
                         input logic mreq, input logic mrdy,
                         input logic [7:0] ctl, input logic [3:0] st, input logic [3:0] fl);
        exp_t e;
        #1;
        reset           = rst_n;
        id_rs1          = rs1;
        id_uses_rs1     = u1;
        id_rs2          = rs2;
        id_uses_rs2     = u2;
        ex_rd           = rd;
        ex_mem_read     = mr;
        ex_branch_taken = bt;
        mem_req         = mreq;
        mem_ready       = mrdy;
        e.nm  = nm;
        e.ctl = ctl;
        e.st  = st;
        e.fl  = fl;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input string nm, input logic rst_n,
                        input logic [7:0] ctl, input logic [3:0] st, input logic [3:0] fl);
        apply(nm, rst_n, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ctl, st, fl);
    endtask

    task automatic mstall(input string nm, input logic rst_n,
                          input logic [7:0] ctl, input logic [3:0] st, input logic [3:0] fl);
        apply(nm, rst_n, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, ctl, st, fl);
    endtask

    // Monitor: mid-cycle, pop one expectation and compare every output
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if (dut_ctl !== e.ctl) begin
                    n_fail++;
                    $display("FAIL %s ctl: got %b expected %b", e.nm, dut_ctl, e.ctl);
                end
                n_tests++;
                if (stall_cycles !== e.st) begin
                    n_fail++;
                    $display("FAIL %s stall_cycles: got %0d expected %0d", e.nm, stall_cycles, e.st);
                end
                n_tests++;
                if (flush_events !== e.fl) begin
                    n_fail++;
                    $display("FAIL %s flush_events: got %0d expected %0d", e.nm, flush_events, e.fl);
                end
            end
        end
    end

    // Stimulus: counters shown are the values before the current cycle's increment
    initial begin
        int guard;
        reset = 1'b0;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        idle("reset_state", 1'b0, C_RST, 4'd0, 4'd0);
        idle("idle_run", 1'b1, C_NORM, 4'd0, 4'd0);

        apply("load_use_rs2", 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU, 4'd0, 4'd0);
        idle("after_load_use", 1'b1, C_NORM, 4'd1, 4'd0);

        apply("x0_dest", 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 4'd1, 4'd0);
        apply("unused_rs1", 1'b1, 5'd7, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 4'd1, 4'd0);

        idle("reset_b", 1'b0, C_RST, 4'd1, 4'd0);
        apply("branch_vs_lu", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_BRANCH, 4'd0, 4'd0);
        idle("after_branch", 1'b1, C_NORM, 4'd0, 4'd1);

        idle("reset_m", 1'b0, C_RST, 4'd0, 4'd1);
        apply("wait_br_1", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_FREEZE, 4'd0, 4'd0);
        apply("wait_br_2", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_FREEZE, 4'd1, 4'd0);
        apply("wait_br_3", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_FREEZE, 4'd2, 4'd0);
        apply("release_br", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, C_BRANCH, 4'd3, 4'd0);
        idle("after_release", 1'b1, C_NORM, 4'd3, 4'd1);
        apply("req_ready_same", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NORM, 4'd3, 4'd1);

        idle("reset_t", 1'b0, C_RST, 4'd3, 4'd1);
        for (int i = 0; i < 5; i++)
            mstall($sformatf("timeout_wait_%0d", i + 1), 1'b1, C_FREEZE, 4'(i), 4'd0);
        mstall("halted", 1'b1, C_HALT, 4'd5, 4'd0);
        apply("halt_absorb", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_HALT, 4'd5, 4'd0);
        idle("reset_from_halt", 1'b0, C_RST, 4'd5, 4'd0);
        idle("run_after_halt", 1'b1, C_NORM, 4'd0, 4'd0);

        for (int i = 0; i < 20; i++)
            apply($sformatf("sat_lu_%0d", i), 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0,
                  C_LU, (i > 15) ? 4'd15 : 4'(i), 4'd0);
        idle("sat_hold", 1'b1, C_NORM, 4'd15, 4'd0);

        idle("reset_w", 1'b0, C_RST, 4'd15, 4'd0);
        mstall("wait_then_reset_1", 1'b1, C_FREEZE, 4'd0, 4'd0);
        mstall("wait_then_reset_2", 1'b1, C_FREEZE, 4'd1, 4'd0);
        mstall("reset_in_wait", 1'b0, C_RST, 4'd2, 4'd0);
        idle("run_after_wait_reset", 1'b1, C_NORM, 4'd0, 4'd0);

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
